bp_fe_bht_gshare: RTL and testbench
===================================

Name: bp_fe_bht_gshare

Overview:
Gshare branch history table for the front end. It XORs a speculative global history register into the PC index and predicts from a table of parametrised-width saturating counters. The speculative history is repaired from per-branch metadata on a mispredict. After reset, a clear state machine initialises every entry before predictions are enabled. The block sits beside the BTB in the fetch stage; resolve updates come from the backend.

Parameters:
vaddr_width_p, 39, virtual PC width.
bht_idx_width_p, 9, table index width; the table has 2**bht_idx_width_p entries.
ghist_width_p, 8, global history length. Must satisfy 2 <= ghist_width_p <= bht_idx_width_p.
ctr_width_p, 2, saturating counter width. Must be >= 2.

Ports:
clk_i  in  1  clock
reset_i  in  1  reset, asynchronous, active-high
init_done_o  out  1  table cleared; the block accepts reads and updates
r_v_i  in  1  prediction lookup valid
r_pc_i  in  vaddr_width_p  fetch PC
predict_o  out  1  predicted direction (1 = taken)
r_idx_o  out  bht_idx_width_p  metadata: index used for this lookup
r_ghist_o  out  ghist_width_p  metadata: history used for this lookup
spec_v_i  in  1  front end commits a prediction; shift history
spec_taken_i  in  1  direction shifted in on spec_v_i
w_v_i  in  1  resolve update valid
w_idx_i  in  bht_idx_width_p  metadata index returned from lookup
w_ghist_i  in  ghist_width_p  metadata history returned from lookup
w_taken_i  in  1  actual direction
w_mispredict_i  in  1  direction was mispredicted; repair history

Behaviour:
- Reset (asynchronous, any cycle):
  - FSM goes to e_clear; clear pointer = 0; ghist_r = 0.
  - init_done_o = 0 and predict_o = 0 immediately.
  - Counter storage has no reset; it is initialised only by the FSM.
- FSM e_clear:
  - Each cycle after reset deasserts, entry[ptr] <= 2**(ctr_width_p-1) - 1 (weakly not-taken) and ptr increments.
  - After writing the last index (ptr all ones), the FSM goes to e_run. The clear takes exactly 2**bht_idx_width_p cycles.
  - During e_clear, w_v_i and spec_v_i are ignored and predict_o = 0.
- FSM e_run: init_done_o = 1. The FSM never leaves e_run except on reset.
- Index: idx = r_pc_i[bht_idx_width_p+1:2] XOR zero-extended ghist_r. r_idx_o = idx and r_ghist_o = ghist_r, both combinational, valid whenever r_v_i = 1.
- Prediction:
  - predict_o = r_v_i & init_done_o & entry[idx][ctr_width_p-1].
  - Zero-cycle combinational lookup, with no bypass. A same-cycle write to the same index is visible on the following cycle.
- Counter update: when w_v_i & init_done_o, entry[w_idx_i] is written at the next edge.
  - Taken: increment, saturating at all-ones.
  - Not taken: decrement, saturating at 0.
  - The update applies regardless of w_mispredict_i. One update per cycle.
- History:
  - spec_v_i alone: ghist_r <= {ghist_r[ghist_width_p-2:0], spec_taken_i}.
  - w_v_i & w_mispredict_i: ghist_r <= {w_ghist_i[ghist_width_p-2:0], w_taken_i}.
  - Repair has priority; a same-cycle spec_v_i is dropped.
  - Neither event: ghist_r holds.
  - A correct resolve (w_mispredict_i = 0) does not touch ghist_r.
- Widths: counter arithmetic is ctr_width_p bits, and saturation is checked before the write. History overflow discards the oldest bit.

Test Plan:
1. idx=4, ghist=2, ctr=2. Deassert reset → init_done_o low for exactly 16 cycles, then high. A lookup at any PC then gives predict_o=0 (entries=01).
2. In e_run, three taken updates to w_idx_i=5 → entry goes 01→10→11→11, and predict_o=1 after the first update. Then four not-taken updates → 11→10→01→00→00, and predict_o=0.
3. ghist_r=0; spec_v_i with taken, then taken → ghist_r=2'b11. r_pc_i=0x20 → r_idx_o=4'b1011, r_ghist_o=2'b11.
4. Same cycle: w_v_i=1, w_mispredict_i=1, w_ghist_i=2'b01, w_taken_i=0, and spec_v_i=1, spec_taken_i=1 → ghist_r=2'b10. entry[w_idx_i] is decremented.
5. Lookup and update to the same idx (entry=01, taken) in one cycle → predict_o=0 that cycle and 1 on the next cycle.
6. Assert reset mid-clear (ptr=7) and again in e_run with ghist_r=2'b11 → init_done_o=0 immediately and ghist_r=0. After reset deasserts, the clear restarts at index 0 and lasts 16 cycles. w_v_i during the clear leaves the entries at 01.

Source files
------------

// File: rtl/bp_fe_bht_gshare.sv
// Gshare branch history table: speculative global history XORed into the PC index,
// table of saturating counters cleared by a small FSM after reset.
module bp_fe_bht_gshare #(
  parameter int unsigned vaddr_width_p   = 39,
  parameter int unsigned bht_idx_width_p = 9,
  parameter int unsigned ghist_width_p   = 8,
  parameter int unsigned ctr_width_p     = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  output logic                       init_done_o,
  input  logic                       r_v_i,
  input  logic [vaddr_width_p-1:0]   r_pc_i,
  output logic                       predict_o,
  output logic [bht_idx_width_p-1:0] r_idx_o,
  output logic [ghist_width_p-1:0]   r_ghist_o,
  input  logic                       spec_v_i,
  input  logic                       spec_taken_i,
  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] w_idx_i,
  input  logic [ghist_width_p-1:0]   w_ghist_i,
  input  logic                       w_taken_i,
  input  logic                       w_mispredict_i
);

  localparam int unsigned entries_lp = 1 << bht_idx_width_p;
  localparam logic [ctr_width_p-1:0] weak_nt_lp = ctr_width_p'((1 << (ctr_width_p - 1)) - 1);
  localparam logic [ctr_width_p-1:0] ctr_max_lp = '1;

  typedef enum logic {e_clear, e_run} state_e;

  state_e                       state_r, state_n;
  logic                         clear_v;
  logic [bht_idx_width_p-1:0]   clr_ptr_r;
  logic [ghist_width_p-1:0]     ghist_r;
  logic [ctr_width_p-1:0]       mem [entries_lp];
  logic [bht_idx_width_p-1:0]   idx;
  logic [ctr_width_p-1:0]       w_ctr, w_ctr_n;

  // Bits of the PC and returned history that never reach the index or history.
  logic unused_bits;
  assign unused_bits = ^{r_pc_i[vaddr_width_p-1:bht_idx_width_p+2], r_pc_i[1:0],
                         w_ghist_i[ghist_width_p-1]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_clear;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    if (state_r == e_clear && clr_ptr_r == '1) state_n = e_run;
  end

  always_comb begin
    init_done_o = 1'b0;
    clear_v     = 1'b0;
    case (state_r)
      e_clear: clear_v     = 1'b1;
      e_run:   init_done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)      clr_ptr_r <= '0;
    else if (clear_v) clr_ptr_r <= clr_ptr_r + bht_idx_width_p'(1);
  end

  // Repair from resolve metadata wins over a same-cycle speculative shift.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ghist_r <= '0;
    end else if (init_done_o) begin
      if (w_v_i && w_mispredict_i) ghist_r <= {w_ghist_i[ghist_width_p-2:0], w_taken_i};
      else if (spec_v_i)           ghist_r <= {ghist_r[ghist_width_p-2:0], spec_taken_i};
    end
  end

  always_comb begin
    idx       = r_pc_i[bht_idx_width_p+1:2] ^ bht_idx_width_p'(ghist_r);
    r_idx_o   = idx;
    r_ghist_o = ghist_r;
    predict_o = r_v_i & init_done_o & mem[idx][ctr_width_p-1];
  end

  always_comb begin
    w_ctr   = mem[w_idx_i];
    w_ctr_n = w_ctr;
    if (w_taken_i) begin
      if (w_ctr != ctr_max_lp) w_ctr_n = w_ctr + ctr_width_p'(1);
    end else begin
      if (w_ctr != '0) w_ctr_n = w_ctr - ctr_width_p'(1);
    end
  end

  // Counter storage has no reset; the clear FSM owns initialisation.
  always_ff @(posedge clk_i) begin
    if (clear_v)                  mem[clr_ptr_r] <= weak_nt_lp;
    else if (w_v_i && init_done_o) mem[w_idx_i]  <= w_ctr_n;
  end

endmodule

// File: tb/tb_bp_fe_bht_gshare.sv
// Directed bench for bp_fe_bht_gshare with a 16-entry table and 2-bit history.
module tb_bp_fe_bht_gshare;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_done;
  logic        r_v;
  logic [15:0] r_pc;
  logic        predict;
  logic [3:0]  r_idx;
  logic [1:0]  r_ghist;
  logic        spec_v, spec_taken;
  logic        w_v;
  logic [3:0]  w_idx;
  logic [1:0]  w_ghist;
  logic        w_taken, w_mispredict;

  int errors = 0;
  int checks = 0;

  bp_fe_bht_gshare #(
    .vaddr_width_p(16), .bht_idx_width_p(4), .ghist_width_p(2), .ctr_width_p(2)
  ) dut (
    .clk_i(clk), .reset_i(reset), .init_done_o(init_done),
    .r_v_i(r_v), .r_pc_i(r_pc), .predict_o(predict), .r_idx_o(r_idx), .r_ghist_o(r_ghist),
    .spec_v_i(spec_v), .spec_taken_i(spec_taken),
    .w_v_i(w_v), .w_idx_i(w_idx), .w_ghist_i(w_ghist), .w_taken_i(w_taken),
    .w_mispredict_i(w_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r_v;
    logic [15:0] pc;
    logic        spec_v, spec_t;
    logic        w_v;
    logic [3:0]  w_idx;
    logic [1:0]  w_ghist;
    logic        w_t, w_mis;
    logic        e_pred;
    logic [3:0]  e_idx;
    logic [1:0]  e_ghist;
  } vec_t;

  localparam int unsigned n_vec_lp = 20;
  vec_t vecs [n_vec_lp];

  function automatic vec_t mk(logic rv, logic [15:0] pc, logic sv, logic st, logic wv,
                              logic [3:0] wi, logic [1:0] wg, logic wt, logic wm,
                              logic ep, logic [3:0] ei, logic [1:0] eg);
    vec_t v;
    v.r_v = rv; v.pc = pc; v.spec_v = sv; v.spec_t = st; v.w_v = wv; v.w_idx = wi;
    v.w_ghist = wg; v.w_t = wt; v.w_mis = wm; v.e_pred = ep; v.e_idx = ei; v.e_ghist = eg;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    r_v = 1'b0; r_pc = '0; spec_v = 1'b0; spec_taken = 1'b0;
    w_v = 1'b0; w_idx = '0; w_ghist = '0; w_taken = 1'b0; w_mispredict = 1'b0;
  endtask

  // Count rising edges until init_done rises, bounded.
  task automatic count_clear(output int n);
    n = 0;
    while (!init_done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // r_v, pc, spec_v, spec_t, w_v, w_idx, w_ghist, w_t, w_mis, e_pred, e_idx, e_ghist
    vecs[0]  = mk(1, 16'h14, 0, 0, 1, 4'd5,  2'b00, 1, 0, 0, 4'd5,  2'b00);
    vecs[1]  = mk(1, 16'h14, 0, 0, 1, 4'd5,  2'b00, 1, 0, 1, 4'd5,  2'b00);
    vecs[2]  = mk(1, 16'h14, 0, 0, 1, 4'd5,  2'b00, 1, 0, 1, 4'd5,  2'b00);
    vecs[3]  = mk(1, 16'h14, 0, 0, 1, 4'd5,  2'b00, 0, 0, 1, 4'd5,  2'b00);
    vecs[4]  = mk(1, 16'h14, 0, 0, 1, 4'd5,  2'b00, 0, 0, 1, 4'd5,  2'b00);
    vecs[5]  = mk(1, 16'h14, 0, 0, 1, 4'd5,  2'b00, 0, 0, 0, 4'd5,  2'b00);
    vecs[6]  = mk(1, 16'h14, 0, 0, 1, 4'd5,  2'b00, 0, 0, 0, 4'd5,  2'b00);
    vecs[7]  = mk(1, 16'h14, 0, 0, 0, 4'd0,  2'b00, 0, 0, 0, 4'd5,  2'b00);
    vecs[8]  = mk(0, 16'h14, 0, 0, 0, 4'd0,  2'b00, 0, 0, 0, 4'd5,  2'b00);
    vecs[9]  = mk(1, 16'h20, 1, 1, 0, 4'd0,  2'b00, 0, 0, 0, 4'd8,  2'b00);
    vecs[10] = mk(1, 16'h20, 1, 1, 0, 4'd0,  2'b00, 0, 0, 0, 4'd9,  2'b01);
    vecs[11] = mk(1, 16'h20, 0, 0, 0, 4'd0,  2'b00, 0, 0, 0, 4'd11, 2'b11);
    vecs[12] = mk(1, 16'h20, 1, 1, 1, 4'd11, 2'b01, 0, 1, 0, 4'd11, 2'b11);
    vecs[13] = mk(1, 16'h20, 0, 0, 0, 4'd0,  2'b00, 0, 0, 0, 4'd10, 2'b10);
    vecs[14] = mk(1, 16'h24, 0, 0, 1, 4'd11, 2'b11, 1, 0, 0, 4'd11, 2'b10);
    vecs[15] = mk(1, 16'h24, 0, 0, 0, 4'd0,  2'b00, 0, 0, 0, 4'd11, 2'b10);
    vecs[16] = mk(1, 16'h24, 0, 0, 1, 4'd11, 2'b00, 1, 0, 0, 4'd11, 2'b10);
    vecs[17] = mk(1, 16'h24, 0, 0, 0, 4'd0,  2'b00, 0, 0, 1, 4'd11, 2'b10);
    vecs[18] = mk(1, 16'h24, 1, 0, 0, 4'd0,  2'b00, 0, 0, 1, 4'd11, 2'b10);
    vecs[19] = mk(1, 16'h24, 0, 0, 0, 4'd0,  2'b00, 0, 0, 0, 4'd9,  2'b00);

    // Power-on reset and initial clear length.
    idle();
    reset = 1'b1;
    r_v = 1'b1;
    #1;
    check("reset_init_done", 32'(init_done), 32'd0);
    check("reset_predict", 32'(predict), 32'd0);
    check("reset_ghist", 32'(r_ghist), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    count_clear(n);
    check("clear_cycles", 32'(n), 32'd16);

    // Reset part-way through the clear; writes and history shifts during the clear are ignored.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    r_v = 1'b1; r_pc = 16'h0C;
    #1;
    check("clear_predict_gated", 32'(predict), 32'd0);
    reset = 1'b1;
    #1;
    check("midclear_reset_init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    w_v = 1'b1; w_idx = 4'd3; w_taken = 1'b1; w_mispredict = 1'b1; w_ghist = 2'b11;
    spec_v = 1'b1; spec_taken = 1'b1;
    count_clear(n);
    check("restart_clear_cycles", 32'(n), 32'd16);
    @(negedge clk);
    idle();
    r_v = 1'b1; r_pc = 16'h0C;
    #1;
    check("clear_ghist", 32'(r_ghist), 32'd0);
    check("clear_idx3", 32'(r_idx), 32'd3);
    check("clear_entry3_weak", 32'(predict), 32'd0);

    // Table-driven run-mode vectors: outputs checked before the edge that commits the row.
    for (int i = 0; i < int'(n_vec_lp); i++) begin
      @(negedge clk);
      r_v = vecs[i].r_v; r_pc = vecs[i].pc;
      spec_v = vecs[i].spec_v; spec_taken = vecs[i].spec_t;
      w_v = vecs[i].w_v; w_idx = vecs[i].w_idx; w_ghist = vecs[i].w_ghist;
      w_taken = vecs[i].w_t; w_mispredict = vecs[i].w_mis;
      #1;
      check($sformatf("vec%0d_predict", i), 32'(predict), 32'(vecs[i].e_pred));
      check($sformatf("vec%0d_idx", i), 32'(r_idx), 32'(vecs[i].e_idx));
      check($sformatf("vec%0d_ghist", i), 32'(r_ghist), 32'(vecs[i].e_ghist));
    end

    // Reset while running with history 11, then a clear with writes attempted throughout.
    @(negedge clk);
    idle();
    spec_v = 1'b1; spec_taken = 1'b1;
    @(negedge clk);
    @(negedge clk);
    spec_v = 1'b0;
    #1;
    check("run_ghist_before_reset", 32'(r_ghist), 32'd3);
    #1;
    reset = 1'b1;
    #1;
    check("run_reset_init_done", 32'(init_done), 32'd0);
    check("run_reset_ghist", 32'(r_ghist), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    w_v = 1'b1; w_idx = 4'd11; w_taken = 1'b1;
    count_clear(n);
    check("run_reset_clear_cycles", 32'(n), 32'd16);
    @(negedge clk);
    idle();
    r_v = 1'b1; r_pc = 16'h2C;
    #1;
    check("post_clear_idx11", 32'(r_idx), 32'd11);
    check("post_clear_entry11_weak", 32'(predict), 32'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
